instruction_fetch_controller: RTL and testbench

INSTRUCTION_FETCH_CONTROLLER -- requirements
Module: instruction_fetch_controller

---
 rtl/instruction_fetch_controller.sv | 129 ++++++++++++
 tb/tb_instruction_fetch_controller.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/instruction_fetch_controller.sv
// rtl/instruction_fetch_controller.sv - PC sequencing and IF/ID register with stall, redirect, halt and fault handling
module instruction_fetch_controller #(
    parameter int                    MEMORY_DEPTH = 32,
    parameter int                    DATA_WIDTH   = 32,
    parameter logic [DATA_WIDTH-1:0] RESET_PC     = 32'h0040_0000
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  Stall,
    input  logic                  Redirect,
    input  logic [DATA_WIDTH-1:0] RedirectTarget,
    input  logic [DATA_WIDTH-1:0] ROMInstruction,
    output logic [DATA_WIDTH-1:0] ROMAddress,
    output logic [DATA_WIDTH-1:0] PC,
    output logic [DATA_WIDTH-1:0] IFID_Instruction,
    output logic [DATA_WIDTH-1:0] IFID_PCPlus4,
    output logic                  IFID_Valid,
    output logic                  Halted,
    output logic                  Fault,
    output logic [15:0]           FetchCount
);

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        HALT  = 2'd1,
        FAULT = 2'd2
    } state_t;

    localparam logic [DATA_WIDTH-1:0] MEM_BYTES = DATA_WIDTH'(4 * MEMORY_DEPTH);

    state_t                  state_q, state_d;
    logic [DATA_WIDTH-1:0]   pc_q, pc_d;
    logic [DATA_WIDTH-1:0]   instr_q, instr_d;
    logic [DATA_WIDTH-1:0]   pcp4_q, pcp4_d;
    logic                    valid_q, valid_d;
    logic [15:0]             count_q, count_d;

    logic [DATA_WIDTH-1:0]   pc_plus4;
    logic [DATA_WIDTH-1:0]   target_offset;
    logic                    pc_out_of_range;
    logic                    target_misaligned;
    logic                    target_in_range;

    // Offsets are taken modulo 2^DATA_WIDTH, so addresses below RESET_PC wrap
    // to huge offsets and fail the same unsigned range compare.
    assign ROMAddress        = pc_q - RESET_PC;
    assign pc_plus4          = pc_q + DATA_WIDTH'(4);
    assign target_offset     = RedirectTarget - RESET_PC;
    assign pc_out_of_range   = (ROMAddress >= MEM_BYTES);
    assign target_misaligned = (RedirectTarget[1:0] != 2'b00);
    assign target_in_range   = (target_offset < MEM_BYTES);

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        instr_d = instr_q;
        pcp4_d  = pcp4_q;
        valid_d = valid_q;
        count_d = count_q;
        case (state_q)
            RUN: begin
                if (Redirect) begin
                    valid_d = 1'b0;
                    if (target_misaligned) begin
                        state_d = FAULT;
                    end else begin
                        pc_d = RedirectTarget;
                    end
                end else if (pc_out_of_range) begin
                    state_d = HALT;
                    valid_d = 1'b0;
                end else if (!Stall) begin
                    pc_d    = pc_plus4;
                    instr_d = ROMInstruction;
                    pcp4_d  = pc_plus4;
                    valid_d = 1'b1;
                    if (count_q != 16'hFFFF) begin
                        count_d = count_q + 16'd1;
                    end
                end
            end
            HALT: begin
                valid_d = 1'b0;
                if (Redirect) begin
                    if (target_misaligned) begin
                        state_d = FAULT;
                    end else if (target_in_range) begin
                        state_d = RUN;
                        pc_d    = RedirectTarget;
                    end
                end
            end
            FAULT: begin
                valid_d = 1'b0;
            end
            default: begin
                state_d = RUN;
                valid_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= RUN;
            pc_q    <= RESET_PC;
            instr_q <= '0;
            pcp4_q  <= '0;
            valid_q <= 1'b0;
            count_q <= 16'd0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            instr_q <= instr_d;
            pcp4_q  <= pcp4_d;
            valid_q <= valid_d;
            count_q <= count_d;
        end
    end

    assign PC               = pc_q;
    assign IFID_Instruction = instr_q;
    assign IFID_PCPlus4     = pcp4_q;
    assign IFID_Valid       = valid_q;
    assign FetchCount       = count_q;
    assign Halted           = (state_q == HALT);
    assign Fault            = (state_q == FAULT);

endmodule

// File: tb/tb_instruction_fetch_controller.sv
// tb/tb_instruction_fetch_controller.sv - directed vector bench for instruction_fetch_controller
module tb_instruction_fetch_controller;

    logic        clk = 1'b0;
    logic        reset;
    logic        Stall;
    logic        Redirect;
    logic [31:0] RedirectTarget;
    logic [31:0] ROMInstruction;
    logic [31:0] ROMAddress;
    logic [31:0] PC;
    logic [31:0] IFID_Instruction;
    logic [31:0] IFID_PCPlus4;
    logic        IFID_Valid;
    logic        Halted;
    logic        Fault;
    logic [15:0] FetchCount;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    // Program memory: word k holds 32'h2000_0000 + k
    assign ROMInstruction = 32'h2000_0000 + (ROMAddress >> 2);

    instruction_fetch_controller #(
        .MEMORY_DEPTH (32),
        .DATA_WIDTH   (32),
        .RESET_PC     (32'h0040_0000)
    ) dut (
        .clk              (clk),
        .reset            (reset),
        .Stall            (Stall),
        .Redirect         (Redirect),
        .RedirectTarget   (RedirectTarget),
        .ROMInstruction   (ROMInstruction),
        .ROMAddress       (ROMAddress),
        .PC               (PC),
        .IFID_Instruction (IFID_Instruction),
        .IFID_PCPlus4     (IFID_PCPlus4),
        .IFID_Valid       (IFID_Valid),
        .Halted           (Halted),
        .Fault            (Fault),
        .FetchCount       (FetchCount)
    );

    typedef struct {
        logic        stall;
        logic        redirect;
        logic [31:0] target;
        logic [31:0] pc;
        logic        valid;
        logic [31:0] instr;
        logic [31:0] pcp4;
        logic        halted;
        logic        fault;
        logic [15:0] count;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input logic s, input logic r, input logic [31:0] t,
                       input logic [31:0] pc, input logic v, input logic [31:0] i,
                       input logic [31:0] p4, input logic h, input logic f,
                       input logic [15:0] c);
        vec_t x;
        x.stall = s; x.redirect = r; x.target = t; x.pc = pc; x.valid = v;
        x.instr = i; x.pcp4 = p4; x.halted = h; x.fault = f; x.count = c;
        vecs.push_back(x);
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic s, input logic r, input logic [31:0] t);
        Stall = s; Redirect = r; RedirectTarget = t;
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, " pc"},     PC,                 32'h0040_0000);
        check({tag, " valid"},  {31'd0, IFID_Valid}, 32'd0);
        check({tag, " instr"},  IFID_Instruction,   32'd0);
        check({tag, " pcp4"},   IFID_PCPlus4,       32'd0);
        check({tag, " count"},  {16'd0, FetchCount}, 32'd0);
        check({tag, " halted"}, {31'd0, Halted},    32'd0);
        check({tag, " fault"},  {31'd0, Fault},     32'd0);
        check({tag, " romaddr"}, ROMAddress,        32'd0);
    endtask

    task automatic do_reset;
        reset = 1'b1;
        step();
        step();
        reset = 1'b0;
    endtask

    initial begin
        logic [15:0] exp_cnt;
        reset = 1'b1;
        drive(1'b0, 1'b0, 32'd0);

        //   s  r  target        pc            v  instr         pcp4          h  f  cnt
        add(0, 0, 32'h0,        32'h0040_0004, 1, 32'h2000_0000, 32'h0040_0004, 0, 0, 1);
        add(0, 0, 32'h0,        32'h0040_0008, 1, 32'h2000_0001, 32'h0040_0008, 0, 0, 2);
        add(1, 0, 32'h0,        32'h0040_0008, 1, 32'h2000_0001, 32'h0040_0008, 0, 0, 2);
        add(1, 0, 32'h0,        32'h0040_0008, 1, 32'h2000_0001, 32'h0040_0008, 0, 0, 2);
        add(1, 0, 32'h0,        32'h0040_0008, 1, 32'h2000_0001, 32'h0040_0008, 0, 0, 2);
        add(0, 0, 32'h0,        32'h0040_000C, 1, 32'h2000_0002, 32'h0040_000C, 0, 0, 3);
        add(1, 1, 32'h0040_0020, 32'h0040_0020, 0, 32'h2000_0002, 32'h0040_000C, 0, 0, 3);
        add(0, 0, 32'h0,        32'h0040_0024, 1, 32'h2000_0008, 32'h0040_0024, 0, 0, 4);
        add(0, 1, 32'h0040_007C, 32'h0040_007C, 0, 32'h2000_0008, 32'h0040_0024, 0, 0, 4);
        add(0, 0, 32'h0,        32'h0040_0080, 1, 32'h2000_001F, 32'h0040_0080, 0, 0, 5);
        add(0, 0, 32'h0,        32'h0040_0080, 0, 32'h2000_001F, 32'h0040_0080, 1, 0, 5);
        add(1, 0, 32'h0,        32'h0040_0080, 0, 32'h2000_001F, 32'h0040_0080, 1, 0, 5);
        add(0, 1, 32'h0040_0000, 32'h0040_0000, 0, 32'h2000_001F, 32'h0040_0080, 0, 0, 5);
        add(0, 0, 32'h0,        32'h0040_0004, 1, 32'h2000_0000, 32'h0040_0004, 0, 0, 6);
        add(0, 1, 32'h003F_FFFC, 32'h003F_FFFC, 0, 32'h2000_0000, 32'h0040_0004, 0, 0, 6);
        add(0, 0, 32'h0,        32'h003F_FFFC, 0, 32'h2000_0000, 32'h0040_0004, 1, 0, 6);
        add(0, 1, 32'h0040_0010, 32'h0040_0010, 0, 32'h2000_0000, 32'h0040_0004, 0, 0, 6);
        add(0, 1, 32'h0040_0200, 32'h0040_0200, 0, 32'h2000_0000, 32'h0040_0004, 0, 0, 6);
        add(0, 0, 32'h0,        32'h0040_0200, 0, 32'h2000_0000, 32'h0040_0004, 1, 0, 6);
        add(0, 1, 32'h0040_0006, 32'h0040_0200, 0, 32'h2000_0000, 32'h0040_0004, 0, 1, 6);
        add(1, 1, 32'h0040_0000, 32'h0040_0200, 0, 32'h2000_0000, 32'h0040_0004, 0, 1, 6);
        add(0, 0, 32'h0,        32'h0040_0200, 0, 32'h2000_0000, 32'h0040_0004, 0, 1, 6);

        step();
        step();
        check_reset_state("reset");
        reset = 1'b0;

        foreach (vecs[k]) begin
            drive(vecs[k].stall, vecs[k].redirect, vecs[k].target);
            step();
            check($sformatf("v%0d pc", k),     PC,                  vecs[k].pc);
            check($sformatf("v%0d valid", k),  {31'd0, IFID_Valid}, {31'd0, vecs[k].valid});
            check($sformatf("v%0d instr", k),  IFID_Instruction,    vecs[k].instr);
            check($sformatf("v%0d pcp4", k),   IFID_PCPlus4,        vecs[k].pcp4);
            check($sformatf("v%0d halted", k), {31'd0, Halted},     {31'd0, vecs[k].halted});
            check($sformatf("v%0d fault", k),  {31'd0, Fault},      {31'd0, vecs[k].fault});
            check($sformatf("v%0d count", k),  {16'd0, FetchCount}, {16'd0, vecs[k].count});
        end

        // Reset while faulted, with redirect and stall asserted
        drive(1'b1, 1'b1, 32'h0040_0040);
        do_reset();
        check_reset_state("rst_fault");

        // Straight run to the end of memory
        drive(1'b0, 1'b0, 32'd0);
        for (int k = 0; k < 32; k++) begin
            step();
            check($sformatf("run%0d instr", k), IFID_Instruction, 32'h2000_0000 + k);
            check($sformatf("run%0d pcp4", k),  IFID_PCPlus4,     32'h0040_0004 + 4 * k);
        end
        check("run count", {16'd0, FetchCount}, 32'd32);
        step();
        check("end pc", PC, 32'h0040_0080);
        check("end halted", {31'd0, Halted}, 32'd1);
        check("end valid", {31'd0, IFID_Valid}, 32'd0);
        drive(1'b0, 1'b1, 32'h0040_0000);
        step();
        check("rerun halted", {31'd0, Halted}, 32'd0);
        check("rerun pc", PC, 32'h0040_0000);

        // Reset mid-stall
        drive(1'b1, 1'b0, 32'd0);
        do_reset();
        check_reset_state("rst_stall");

        // Saturation: 31 fetches then a redirect back to start, repeated
        exp_cnt = 16'd0;
        for (int it = 0; it < 2200; it++) begin
            drive(1'b0, 1'b0, 32'd0);
            for (int k = 0; k < 31; k++) begin
                step();
                if (exp_cnt != 16'hFFFF) exp_cnt = exp_cnt + 16'd1;
            end
            drive(1'b0, 1'b1, 32'h0040_0000);
            step();
            if (it == 0) check("sat first lap", {16'd0, FetchCount}, {16'd0, exp_cnt});
        end
        check("sat model", {16'd0, exp_cnt}, 32'h0000_FFFF);
        check("sat count", {16'd0, FetchCount}, 32'h0000_FFFF);
        drive(1'b0, 1'b0, 32'd0);
        step();
        check("sat hold valid", {31'd0, IFID_Valid}, 32'd1);
        check("sat hold count", {16'd0, FetchCount}, 32'h0000_FFFF);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
